// File: rtl/move_exec_arbiter.sv
// rtl/move_exec_arbiter.sv - round-robin arbiter sharing one move executor between requesters
module move_exec_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    parameter int TIMEOUT = 4,
    parameter int MOVE_W  = 16,
    parameter int BOARD_W = 64
) (
    input  logic                             clk_in,
    input  logic                             rst_in,
    input  logic [NUM_REQ-1:0]               req_valid_in,
    output logic [NUM_REQ-1:0]               req_ready_out,
    input  logic [NUM_REQ-1:0][MOVE_W-1:0]   req_move_in,
    input  logic [NUM_REQ-1:0][BOARD_W-1:0]  req_board_in,
    output logic                             exec_valid_out,
    output logic [MOVE_W-1:0]                exec_move_out,
    output logic [BOARD_W-1:0]               exec_board_out,
    input  logic                             exec_valid_in,
    input  logic [BOARD_W-1:0]               exec_board_in,
    input  logic                             exec_captured_in,
    output logic                             resp_valid_out,
    input  logic                             resp_ready_in,
    output logic [ID_W-1:0]                  resp_id_out,
    output logic [BOARD_W-1:0]               resp_board_out,
    output logic                             resp_captured_out,
    output logic [15:0]                      moves_done_out,
    output logic                             error_out
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t               state_q;
    logic [ID_W-1:0]      ptr_q;
    logic [ID_W-1:0]      id_q;
    logic [CNT_W-1:0]     cnt_q;
    // After reset the executor may still return the discarded move; for this
    // many cycles an out-of-state exec_valid_in is swallowed instead of
    // being flagged as a protocol error.
    logic [CNT_W-1:0]     guard_q;
    logic                 exec_valid_q;
    logic [MOVE_W-1:0]    exec_move_q;
    logic [BOARD_W-1:0]   exec_board_q;
    logic                 resp_valid_q;
    logic [ID_W-1:0]      resp_id_q;
    logic [BOARD_W-1:0]   resp_board_q;
    logic                 resp_captured_q;
    logic [15:0]          moves_done_q;
    logic                 error_q;

    logic                 win_found;
    logic [ID_W-1:0]      win_id;
    logic [ID_W-1:0]      ptr_d;

    // Round-robin search starting at the pointer, wrapping modulo NUM_REQ
    always_comb begin
        int idx;
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!win_found && req_valid_in[idx]) begin
                win_found = 1'b1;
                win_id    = ID_W'(idx);
            end
        end
    end

    // Pointer moves to the requester just after the winner
    always_comb begin
        ptr_d = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
    end

    // Accept is combinational, only in IDLE and never while reset is held
    always_comb begin
        req_ready_out = '0;
        if (rst_in && (state_q == IDLE) && win_found) begin
            req_ready_out = NUM_REQ'(1) << win_id;
        end
    end

    // Main FSM with registered executor and response outputs
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q         <= IDLE;
            ptr_q           <= '0;
            id_q            <= '0;
            cnt_q           <= '0;
            guard_q         <= CNT_W'(TIMEOUT);
            exec_valid_q    <= 1'b0;
            exec_move_q     <= '0;
            exec_board_q    <= '0;
            resp_valid_q    <= 1'b0;
            resp_id_q       <= '0;
            resp_board_q    <= '0;
            resp_captured_q <= 1'b0;
            moves_done_q    <= '0;
            error_q         <= 1'b0;
        end else begin
            if (guard_q != '0) begin
                guard_q <= guard_q - 1'b1;
            end
            if (exec_valid_in && (state_q != WAIT)) begin
                if (guard_q == '0) begin
                    error_q <= 1'b1;
                end
                guard_q <= '0;
            end
            case (state_q)
                IDLE: begin
                    if (win_found) begin
                        id_q         <= win_id;
                        exec_move_q  <= req_move_in[win_id];
                        exec_board_q <= req_board_in[win_id];
                        exec_valid_q <= 1'b1;
                        ptr_q        <= ptr_d;
                        state_q      <= ISSUE;
                    end
                end
                ISSUE: begin
                    exec_valid_q <= 1'b0;
                    cnt_q        <= '0;
                    state_q      <= WAIT;
                end
                WAIT: begin
                    if (exec_valid_in) begin
                        resp_board_q    <= exec_board_in;
                        resp_captured_q <= exec_captured_in;
                        resp_id_q       <= id_q;
                        resp_valid_q    <= 1'b1;
                        state_q         <= RESP;
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        error_q <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready_in) begin
                        resp_valid_q <= 1'b0;
                        moves_done_q <= moves_done_q + 16'd1;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign exec_valid_out    = exec_valid_q;
    assign exec_move_out     = exec_move_q;
    assign exec_board_out    = exec_board_q;
    assign resp_valid_out    = resp_valid_q;
    assign resp_id_out       = resp_id_q;
    assign resp_board_out    = resp_board_q;
    assign resp_captured_out = resp_captured_q;
    assign moves_done_out    = moves_done_q;
    assign error_out         = error_q;

endmodule

// File: tb/tb_move_exec_arbiter.sv
// tb/tb_move_exec_arbiter.sv - scoreboard bench for move_exec_arbiter
module tb_move_exec_arbiter;

    localparam int N       = 2;
    localparam int TIMEOUT = 4;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [N-1:0]          req_valid;
    logic [N-1:0]          req_ready;
    logic [N-1:0][15:0]    req_move;
    logic [N-1:0][63:0]    req_board;
    logic                  exec_valid_out;
    logic [15:0]           exec_move_out;
    logic [63:0]           exec_board_out;
    logic                  exec_valid_in;
    logic [63:0]           exec_board_in;
    logic                  exec_captured_in;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [0:0]            resp_id;
    logic [63:0]           resp_board;
    logic                  resp_captured;
    logic [15:0]           moves_done;
    logic                  error_flag;

    move_exec_arbiter #(.NUM_REQ(N), .TIMEOUT(TIMEOUT)) dut (
        .clk_in(clk), .rst_in(rst_n),
        .req_valid_in(req_valid), .req_ready_out(req_ready),
        .req_move_in(req_move), .req_board_in(req_board),
        .exec_valid_out(exec_valid_out), .exec_move_out(exec_move_out),
        .exec_board_out(exec_board_out), .exec_valid_in(exec_valid_in),
        .exec_board_in(exec_board_in), .exec_captured_in(exec_captured_in),
        .resp_valid_out(resp_valid), .resp_ready_in(resp_ready),
        .resp_id_out(resp_id), .resp_board_out(resp_board),
        .resp_captured_out(resp_captured), .moves_done_out(moves_done),
        .error_out(error_flag)
    );

    always #5 clk = ~clk;

    // One-cycle executor stub: answers in the cycle after it sees valid
    logic        stub_on, stub_v, spur_v, seen;
    logic [63:0] pend_board;
    logic        pend_cap;
    assign exec_valid_in = stub_v | spur_v;

    initial begin
        stub_v = 0; seen = 0; pend_board = '0; pend_cap = 0;
        exec_board_in = '0; exec_captured_in = 0;
    end

    always @(negedge clk) begin
        stub_v           = seen;
        exec_board_in    = pend_board;
        exec_captured_in = pend_cap;
        seen             = exec_valid_out && stub_on;
        pend_board       = exec_board_out + 64'(exec_move_out) + 64'd1;
        pend_cap         = exec_move_out[0];
    end

    typedef struct {
        int          id;
        logic [63:0] board;
        logic        cap;
    } exp_t;

    exp_t        sb[$];
    int          grants[$];
    int          grant_cyc[$];
    int          checks = 0, errors = 0;
    int          cyc = 0, ptr_m = 0, mdone = 0, last_grant = -10;
    logic [15:0] last_move;
    logic [63:0] last_board;
    logic        prev_rv = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // Observe the handshakes of the current cycle, then advance one cycle
    task automatic cycle();
        int   w;
        exp_t e;
        #1;
        if (req_ready != '0) begin
            w = pick(req_valid, ptr_m);
            check("grant_onehot", 64'(req_ready), (w < 0) ? 64'd0 : (64'd1 << w));
            if ((req_ready & req_valid) != '0 && w >= 0) begin
                if (stub_on) begin
                    e.id    = w;
                    e.board = req_board[w] + 64'(req_move[w]) + 64'd1;
                    e.cap   = req_move[w][0];
                    sb.push_back(e);
                end
                grants.push_back(w);
                grant_cyc.push_back(cyc);
                last_grant = cyc;
                last_move  = req_move[w];
                last_board = req_board[w];
                ptr_m      = (w + 1) % N;
            end
        end
        if (exec_valid_out) begin
            check("exec_latency", 64'(cyc), 64'(last_grant + 1));
            check("exec_move", 64'(exec_move_out), 64'(last_move));
            check("exec_board", exec_board_out, last_board);
        end
        if (resp_valid && !prev_rv) check("resp_latency", 64'(cyc), 64'(last_grant + 3));
        prev_rv = resp_valid;
        if (resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                check("resp_unexpected", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("resp_id", 64'(resp_id), 64'(e.id));
                check("resp_board", resp_board, e.board);
                check("resp_cap", 64'(resp_captured), 64'(e.cap));
                mdone++;
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic randomize_req(input int i);
        req_move[i]  = 16'($urandom);
        req_board[i] = {$urandom, $urandom};
    endtask

    task automatic do_reset(input int n);
        rst_n = 0;
        repeat (n) cycle();
        sb.delete();
        ptr_m = 0; mdone = 0; prev_rv = 0;
        rst_n = 1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int base, g, h, n;
        logic [63:0] snap_board;
        logic        snap_id, snap_cap;

        rst_n = 0; req_valid = '0; resp_ready = 1; stub_on = 1; spur_v = 0;
        for (int i = 0; i < N; i++) randomize_req(i);
        @(negedge clk);

        // Reset state, with requests pending during reset
        req_valid = 2'b11;
        rst_n = 0;
        cycle(); cycle();
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_exec_valid", 64'(exec_valid_out), 64'd0);
        check("rst_exec_board", exec_board_out, 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_moves", 64'(moves_done), 64'd0);
        check("rst_error", 64'(error_flag), 64'd0);
        req_valid = '0;
        do_reset(1);
        repeat (6) cycle();

        // Single request from requester 0
        req_move[0] = 16'h0c1c; req_board[0] = 64'h1;
        req_valid = 2'b01;
        #1 check("single_ready", 64'(req_ready), 64'd1);
        cycle();
        req_valid = '0;
        repeat (5) cycle();
        check("single_done", 64'(moves_done), 64'd1);
        check("single_err", 64'(error_flag), 64'd0);

        // Lone requester 1, then contention starting from pointer 0
        randomize_req(1);
        req_valid = 2'b10;
        cycle();
        req_valid = '0;
        repeat (5) cycle();
        base = grants.size();
        req_valid = 2'b11;
        n = 0;
        while (grants.size() < base + 4 && n < 40) begin
            g = grants.size();
            cycle();
            n++;
            if (grants.size() > g) randomize_req(grants[g]);
        end
        req_valid = '0;
        repeat (5) cycle();
        check("cont_count", 64'(grants.size() - base), 64'd4);
        for (int i = 0; i < 4 && base + i < grants.size(); i++) begin
            check("cont_order", 64'(grants[base + i]), 64'(i % 2));
            if (i > 0) check("cont_spacing", 64'(grant_cyc[base + i] - grant_cyc[base + i - 1]), 64'd4);
        end
        check("cont_done", 64'(moves_done), 64'(mdone));

        // Backpressure: hold response for 5 cycles with requests waiting
        resp_ready = 0;
        randomize_req(0);
        req_valid = 2'b01;
        cycle();
        req_valid = 2'b11;
        n = 0;
        while (!resp_valid && n < 10) begin
            cycle();
            n++;
        end
        check("bp_resp_seen", 64'(resp_valid), 64'd1);
        snap_board = resp_board; snap_id = resp_id; snap_cap = resp_captured;
        repeat (5) begin
            check("bp_valid", 64'(resp_valid), 64'd1);
            check("bp_board", resp_board, snap_board);
            check("bp_id", 64'(resp_id), 64'(snap_id));
            check("bp_cap", 64'(resp_captured), 64'(snap_cap));
            #1 check("bp_ready", 64'(req_ready), 64'd0);
            cycle();
        end
        resp_ready = 1;
        h = cyc;
        cycle();
        cycle();
        check("bp_regrant", 64'(last_grant), 64'(h + 1));
        req_valid = '0;
        repeat (5) cycle();
        check("bp_done", 64'(moves_done), 64'(mdone));

        // Timeout: executor never answers
        stub_on = 0;
        req_valid = 2'b01;
        g = cyc;
        cycle();
        req_valid = '0;
        while (!error_flag && cyc < g + 20) cycle();
        check("to_cycle", 64'(cyc), 64'(g + TIMEOUT + 2));
        check("to_error", 64'(error_flag), 64'd1);
        check("to_moves", 64'(moves_done), 64'(mdone));
        stub_on = 1;
        randomize_req(0);
        req_valid = 2'b01;
        h = cyc;
        cycle();
        req_valid = '0;
        check("to_accept", 64'(last_grant), 64'(h));
        repeat (5) cycle();
        check("to_sticky", 64'(error_flag), 64'd1);
        check("to_done", 64'(moves_done), 64'(mdone));

        // Reset during WAIT with executor valid during and after reset
        stub_on = 0;
        req_valid = 2'b10;
        cycle();
        req_valid = '0;
        cycle();
        rst_n = 0;
        cycle();
        spur_v = 1;
        do_reset(1);
        cycle();
        spur_v = 0;
        check("mid_error", 64'(error_flag), 64'd0);
        check("mid_resp", 64'(resp_valid), 64'd0);
        check("mid_exec", 64'(exec_valid_out), 64'd0);
        check("mid_moves", 64'(moves_done), 64'd0);
        check("mid_board", exec_board_out, 64'd0);
        stub_on = 1;
        req_valid = 2'b11;
        cycle();
        req_valid = '0;
        check("mid_ptr", 64'(grants[grants.size() - 1]), 64'd0);
        repeat (6) cycle();
        check("mid_done", 64'(moves_done), 64'd1);
        check("mid_error2", 64'(error_flag), 64'd0);

        // Spurious executor valid while idle
        spur_v = 1;
        cycle();
        spur_v = 0;
        cycle();
        check("spur_error", 64'(error_flag), 64'd1);
        check("spur_resp", 64'(resp_valid), 64'd0);
        check("spur_moves", 64'(moves_done), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
